fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupled, prefetching instruction fetch unit for the RV32 core, sitting between the instruction memory port and decode. It keeps up to MAX_OUTSTANDING in-order memory requests in flight and buffers returned words, each with its PC, in a DEPTH-entry queue. Decode consumes them through a valid/ready handshake. A redirect (branch, jump, trap) flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

## Interface
- BOOT_ADDR, 32'h0000_0000: PC of the first fetch after reset.
- DEPTH, 4: instruction queue entries; power of two, >= 2.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory requests; 1..DEPTH.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts request this cycle.
- req_addr  out  32  word-aligned fetch address.
- res_valid  in  1  read response valid; responses return in request order, one per accepted request, cannot be back-pressured.
- res_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes head.
- out_pc  out  32  PC of head instruction.
- out_instr  out  32  head instruction word.
- out_fault  out  1  head is an instruction-address-misaligned fault entry.

## Operation
- Registers: fetch_pc, queue (count 0..DEPTH, rd/wr pointers wrapping mod DEPTH), PC tag FIFO (depth MAX_OUTSTANDING), outstanding counter, drop counter; widths $clog2(N+1).
- Issue: req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && count + outstanding < DEPTH. This guarantees the queue never overflows. req_addr = fetch_pc.
- On req_valid && req_ready: push fetch_pc to the tag FIFO, fetch_pc += 4 (wraps mod 2^32), outstanding++.
- On res_valid: pop a tag, outstanding--. If drop > 0, discard the word and decrement drop. Otherwise write {tag, res_data, fault=0} to the queue.
- On out_valid && out_ready: pop the head.
- Redirect: the queue is emptied and fetch_pc <= {redirect_pc[31:2], 2'b00}. drop <= outstanding after this cycle's accept/response updates, so every request issued before the redirect is discarded.
- Simultaneous events:
  - A pop in the redirect cycle completes; decode has consumed it.
  - A response arriving in the redirect cycle is stale and is discarded.
  - A push and a pop in the same cycle leave count unchanged.
  - Redirect during an active drop adds to drop.
- State machine: RUN (normal). FAULT exists only with FETCH_ALIGN_CHECK_EN.

## Timing
- Reset values: req_valid 0, req_addr BOOT_ADDR, out_valid 0, out_pc 0, out_instr 0, out_fault 0, count/outstanding/drop 0, state RUN.
- First cycle after rst deasserts: req_valid=1, req_addr=BOOT_ADDR.
- Queue write is registered with no bypass. A response at cycle t appears as out_valid at t+1.
- Redirect at cycle t:
  - out_valid is 0 at t+1.
  - req_valid is 0 at t.
  - First new request is at t+1 with req_addr = redirect_pc, if credit allows.
- Full (count + outstanding == DEPTH): req_valid stays low until a pop.
- Empty: out_valid=0; out_pc and out_instr hold their last values.
- Reset mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility and must not arrive.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 enters FAULT.
  - In FAULT, no requests issue and stale responses still drain via drop.
  - The queue holds a single entry {pc=redirect_pc, instr=0, fault=1}, with out_valid=1 from the next cycle.
  - Popping it leaves the queue empty while FAULT holds.
  - FAULT exits only on a redirect to an aligned PC.
- FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] is ignored, out_fault is constant 0, there is no FAULT state.

## Test plan
- Reset, memory with zero-wait responses and out_ready=1 -> requests at BOOT_ADDR, +4, +8, ...; out_pc/out_instr match in order, one per cycle in steady state.
- out_ready=0, DEPTH=4 -> exactly 4 requests accepted, then req_valid low; first pop re-enables exactly one request.
- 2 outstanding requests, redirect_pc=32'h100, then both stale responses return -> both discarded; next out_pc=32'h100 with the correct word.
- Redirect coincident with res_valid and with out handshake -> that response is dropped, the pop completes, the queue is empty next cycle.
- req_ready=0 for 5 cycles -> req_addr stable, no queue change; MAX_OUTSTANDING=1 -> never 2 in flight.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=32'h102 -> out_valid=1, out_fault=1, out_pc=32'h102, no requests; redirect to 32'h200 -> normal fetch resumes at 32'h200.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled, prefetching instruction fetch unit between the
// instruction memory port and decode. Keeps up to MAX_OUTSTANDING in-order
// requests in flight, buffers returned words with their PCs in a DEPTH-entry
// queue, and flushes and restarts on a redirect.
// Optional feature: define FETCH_ALIGN_CHECK_EN to turn a misaligned redirect
// into a single fault entry (FAULT state) instead of silently aligning it.
module fetch_queue #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count, count_d;
  logic [PW-1:0] rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d;
  logic [OW-1:0] outstanding, outstanding_d, drop, drop_d;
  logic [TW-1:0] tag_rd, tag_wr;
  logic [31:0]   tag_mem [MAX_OUTSTANDING];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic          accept, pop, keep_res, run_ok, fault_redirect, head_new;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [31:0]   wr_pc, wr_instr;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [0:0] {RUN, FAULT} state_t;
  state_t state_q, state_d;

  assign fault_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign run_ok         = (state_q == RUN);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: only a redirect moves between RUN and FAULT.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = fault_redirect ? FAULT : RUN;
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb  = ^redirect_pc[1:0];
  assign fault_redirect = 1'b0;
  assign run_ok         = 1'b1;
  assign out_fault      = 1'b0;
`endif

  // Credit check keeps count + outstanding <= DEPTH, so a returning word
  // always has a free queue slot and responses never need back-pressure.
  assign req_valid = !rst && !redirect_valid && run_ok
                     && (int'(outstanding) < MAX_OUTSTANDING)
                     && (int'(count) + int'(outstanding) < DEPTH);
  assign req_addr  = fetch_pc;
  assign out_valid = (count != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = out_valid && out_ready;
  // A response in the redirect cycle or while draining is stale.
  assign keep_res  = res_valid && (drop == '0) && !redirect_valid;

  // Queue write source: a kept response, or the synthetic fault entry.
  // NOTE: every always_comb output gets a default first, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    wr_en    = keep_res;
    wr_idx   = wr_ptr;
    wr_pc    = tag_mem[tag_rd];
    wr_instr = res_data;
    if (fault_redirect) begin
      wr_en    = 1'b1;
      wr_idx   = '0;
      wr_pc    = redirect_pc;
      wr_instr = '0;
    end
  end

  // Next values of the counters and queue pointers.
  always_comb begin
    outstanding_d = outstanding;
    if (accept && !res_valid)      outstanding_d = outstanding + OW'(1);
    else if (!accept && res_valid) outstanding_d = outstanding - OW'(1);

    drop_d = drop;
    if (res_valid && (drop != '0)) drop_d = drop - OW'(1);
    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect_valid) drop_d = outstanding_d;

    count_d  = count;
    rd_ptr_d = rd_ptr;
    wr_ptr_d = wr_ptr;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr + PW'(1);
      if (wr_en && !pop)      count_d = count + CW'(1);
      else if (!wr_en && pop) count_d = count - CW'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_idx + PW'(1);
      if (fault_redirect) count_d = CW'(1);
    end
  end

  // The written entry becomes the head when it is the only one left.
  assign head_new = wr_en && (count_d == CW'(1));

  // Control state and registered head outputs; head holds when the queue empties.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= BOOT_ADDR;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      drop        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      out_pc      <= '0;
      out_instr   <= '0;
    end else begin
      count       <= count_d;
      rd_ptr      <= rd_ptr_d;
      wr_ptr      <= wr_ptr_d;
      outstanding <= outstanding_d;
      drop        <= drop_d;
      if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)    fetch_pc <= fetch_pc + 32'd4;
      if (accept)    tag_wr <= (tag_wr == TAG_LAST) ? '0 : tag_wr + TW'(1);
      if (res_valid) tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + TW'(1);
      if (count_d != '0) begin
        out_pc    <= head_new ? wr_pc    : q_pc[rd_ptr_d];
        out_instr <= head_new ? wr_instr : q_instr[rd_ptr_d];
      end
    end
  end

  // Queue and tag storage writes.
  // NOTE: storage arrays are not reset; count, pointers and outstanding already mark every slot invalid.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= fetch_pc;
    if (wr_en) begin
      q_pc[wr_idx]    <= wr_pc;
      q_instr[wr_idx] <= wr_instr;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic q_fault [DEPTH];
  logic out_fault_q;

  // Fault flag storage alongside the queue entries.
  always_ff @(posedge clk) begin
    if (wr_en) q_fault[wr_idx] <= fault_redirect;
  end

  // Registered head fault flag, loaded like out_pc/out_instr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 out_fault_q <= 1'b0;
    else if (count_d != '0)  out_fault_q <= head_new ? fault_redirect : q_fault[rd_ptr_d];
  end

  assign out_fault = out_fault_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven bench for fetch_queue with the
// default parameters (DEPTH=4, MAX_OUTSTANDING=2, BOOT_ADDR=0). The bench acts
// as the memory: each response is given in the vector table by hand.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        rs;
    logic [31:0] d;
    logic        rd;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_ov;
    logic [31:0] e_op;
    logic [31:0] e_oi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rr, input logic rs, input logic [31:0] d,
                              input logic rd, input logic [31:0] rpc, input logic ordy,
                              input logic e_rv, input logic [31:0] e_ra, input logic e_ov,
                              input logic [31:0] e_op, input logic [31:0] e_oi);
    vec_t v;
    v.rr = rr; v.rs = rs; v.d = d; v.rd = rd; v.rpc = rpc; v.ordy = ordy;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_ov = e_ov; v.e_op = e_op; v.e_oi = e_oi;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let them settle.
  task automatic drive(input logic rr, input logic rs, input logic [31:0] d,
                       input logic rd, input logic [31:0] rpc, input logic ordy);
    @(negedge clk);
    req_ready      = rr;
    res_valid      = rs;
    res_data       = d;
    redirect_valid = rd;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming with zero-wait memory: response one cycle after accept.
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 1, 1, 32'h00,  0, 32'h0,  32'h0));
    vecs.push_back(mk(1, 1, 32'h1000_0000, 0, 32'h0, 1, 1, 32'h04,  0, 32'h0,  32'h0));
    vecs.push_back(mk(1, 1, 32'h1000_0004, 0, 32'h0, 1, 1, 32'h08,  1, 32'h0,  32'h1000_0000));
    vecs.push_back(mk(1, 1, 32'h1000_0008, 0, 32'h0, 1, 1, 32'h0C,  1, 32'h4,  32'h1000_0004));
    vecs.push_back(mk(1, 1, 32'h1000_000C, 0, 32'h0, 1, 1, 32'h10,  1, 32'h8,  32'h1000_0008));
    // Decode stalls: queue fills, req_valid drops at count+outstanding==4.
    vecs.push_back(mk(1, 1, 32'h1000_0010, 0, 32'h0, 0, 1, 32'h14,  1, 32'hC,  32'h1000_000C));
    vecs.push_back(mk(1, 1, 32'h1000_0014, 0, 32'h0, 0, 1, 32'h18,  1, 32'hC,  32'h1000_000C));
    vecs.push_back(mk(1, 1, 32'h1000_0018, 0, 32'h0, 0, 0, 32'h1C,  1, 32'hC,  32'h1000_000C));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 0, 32'h1C,  1, 32'hC,  32'h1000_000C));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 0, 32'h1C,  1, 32'hC,  32'h1000_000C));
    // One pop re-enables exactly one request.
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 1, 0, 32'h1C,  1, 32'hC,  32'h1000_000C));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 1, 32'h1C,  1, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 1, 32'h1000_001C, 0, 32'h0, 0, 0, 32'h20,  1, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 0, 32'h20,  1, 32'h10, 32'h1000_0010));
    // Redirect flushes a full queue; then req_ready low for 5 cycles.
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h40, 0, 0, 32'h20, 1, 32'h10, 32'h1000_0010));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0, 0, 1, 32'h40,  0, 32'h10, 32'h1000_0010));
    // Two in flight hits MAX_OUTSTANDING; redirect to 0x100 drops both.
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 1, 32'h40,  0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 1, 32'h44,  0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 0, 32'h48,  0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h100, 0, 0, 32'h48, 0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 1, 32'h1000_0040, 0, 32'h0, 0, 0, 32'h100, 0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(1, 1, 32'h1000_0044, 0, 32'h0, 0, 1, 32'h100, 0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(0, 1, 32'h1000_0100, 0, 32'h0, 0, 1, 32'h104, 0, 32'h10, 32'h1000_0010));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0, 1, 1, 32'h104, 1, 32'h100, 32'h1000_0100));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0, 0, 1, 32'h104, 0, 32'h100, 32'h1000_0100));
    // Redirect coincident with a response and a completed pop.
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 1, 32'h104, 0, 32'h100, 32'h1000_0100));
    vecs.push_back(mk(0, 1, 32'h1000_0104, 0, 32'h0, 0, 1, 32'h108, 0, 32'h100, 32'h1000_0100));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0, 0, 1, 32'h108, 1, 32'h104, 32'h1000_0104));
    vecs.push_back(mk(1, 1, 32'h1000_0108, 1, 32'h200, 1, 0, 32'h10C, 1, 32'h104, 32'h1000_0104));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0, 1, 1, 32'h200, 0, 32'h104, 32'h1000_0104));

    // Reset state.
    #2;
    check("reset req_valid", 32'(req_valid), 32'h0);
    check("reset req_addr",  req_addr,       32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_pc",    out_pc,         32'h0);
    check("reset out_instr", out_instr,      32'h0);
    check("reset out_fault", 32'(out_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rr, vecs[i].rs, vecs[i].d, vecs[i].rd, vecs[i].rpc, vecs[i].ordy);
      check($sformatf("v%0d req_valid", i), 32'(req_valid), 32'(vecs[i].e_rv));
      check($sformatf("v%0d req_addr", i),  req_addr,       vecs[i].e_ra);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d out_pc", i),    out_pc,         vecs[i].e_op);
      check($sformatf("v%0d out_instr", i), out_instr,      vecs[i].e_oi);
      check($sformatf("v%0d out_fault", i), 32'(out_fault), 32'h0);
    end

    // Misaligned redirect.
    drive(0, 0, 32'h0, 1, 32'h102, 0);
    check("mis redirect req_valid", 32'(req_valid), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    check("fault req_valid", 32'(req_valid), 32'h0);
    check("fault out_valid", 32'(out_valid), 32'h1);
    check("fault out_pc",    out_pc,         32'h102);
    check("fault out_instr", out_instr,      32'h0);
    check("fault out_fault", 32'(out_fault), 32'h1);
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    check("fault pop req_valid", 32'(req_valid), 32'h0);
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    check("fault empty out_valid", 32'(out_valid), 32'h0);
    check("fault empty req_valid", 32'(req_valid), 32'h0);
    drive(1, 0, 32'h0, 1, 32'h200, 0);
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    check("fault exit req_valid", 32'(req_valid), 32'h1);
    check("fault exit req_addr",  req_addr,       32'h200);
    check("fault exit out_valid", 32'(out_valid), 32'h0);
`else
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    check("mis aligned req_valid", 32'(req_valid), 32'h1);
    check("mis aligned req_addr",  req_addr,       32'h100);
    check("mis out_valid",         32'(out_valid), 32'h0);
    check("mis out_fault",         32'(out_fault), 32'h0);
`endif

    // Reset in the middle of operation, with a request in flight.
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst req_valid", 32'(req_valid), 32'h0);
    check("midrst req_addr",  req_addr,       32'h0);
    check("midrst out_valid", 32'(out_valid), 32'h0);
    check("midrst out_pc",    out_pc,         32'h0);
    check("midrst out_instr", out_instr,      32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst req_valid", 32'(req_valid), 32'h1);
    check("postrst req_addr",  req_addr,       32'h0);
    check("postrst out_valid", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
